// File: rtl/video_pkg.sv
// Shared definitions for the video capture and display paths.
package video_pkg;

   localparam int DEF_COLOR_DEPTH = 8;
   localparam int PIX_W           = 3 * DEF_COLOR_DEPTH;

   // Default window placement, shared with the display side that reads the buffer.
   localparam int DEF_WIN_X_START = 640;
   localparam int DEF_WIN_Y_START = 412;
   localparam int DEF_WIN_WIDTH   = 256;
   localparam int DEF_WIN_HEIGHT  = 256;
   localparam int DEF_ADDR_BITS   = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_e;

   function automatic int pix_width(input int color_depth);
      return 3 * color_depth;
   endfunction

endpackage

// File: rtl/video_xy_tracker.sv
// Sync edge detection and saturating active-area x/y position counters.
module video_xy_tracker
   import video_pkg::*;
#(
   parameter int X_BITS = 12,
   parameter int Y_BITS = 12
) (
   input  logic              pix_clk,
   input  logic              rstn,
   input  logic              vs_in,
   input  logic              de_in,
   output logic              vs_rise,
   output logic              de_fall,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y
);

   logic              vs_d_q, vs_d_d;
   logic              de_d_q, de_d_d;
   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;

   // Edges and next counter values; x is the column of the pixel currently on the bus.
   always_comb begin
      vs_d_d  = vs_in;
      de_d_d  = de_in;
      vs_rise = vs_in & ~vs_d_q;
      de_fall = ~de_in & de_d_q;
      x_d     = x_q;
      y_d     = y_q;
      if (vs_rise) begin
         x_d = '0;
         y_d = '0;
      end else if (de_fall) begin
         x_d = '0;
         if (y_q != '1) y_d = y_q + 1'b1;
      end else if (de_in && (x_q != '1)) begin
         x_d = x_q + 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         vs_d_q <= 1'b0;
         de_d_q <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         vs_d_q <= vs_d_d;
         de_d_q <= de_d_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

   assign x = x_q;
   assign y = y_q;

endmodule

// File: rtl/video_window_capture.sv
// Captures one rectangular window of an incoming raster into a frame-buffer RAM.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | waiting for cap_start
//  ST_ARM     | armed, waiting for the next frame start
//  ST_CAPTURE | writing window pixels; early frame start restarts window
//  ST_DONE    | one cycle: final write lands, cap_done, frame_cnt bump
module video_window_capture
   import video_pkg::*;
#(
   parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
   parameter int X_BITS      = 12,
   parameter int Y_BITS      = 12,
   parameter int WIN_X_START = DEF_WIN_X_START,
   parameter int WIN_Y_START = DEF_WIN_Y_START,
   parameter int WIN_WIDTH   = DEF_WIN_WIDTH,
   parameter int WIN_HEIGHT  = DEF_WIN_HEIGHT,
   parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
   input  logic                     pix_clk,
   input  logic                     rstn,
   input  logic                     vs_in,
   input  logic                     hs_in,
   input  logic                     de_in,
   input  logic [3*COLOR_DEPTH-1:0] pixel_in,
   input  logic                     cap_start,
   input  logic                     cap_continuous,
   output logic                     cap_busy,
   output logic                     cap_done,
   output logic                     err_short,
   output logic [7:0]               frame_cnt,
   output logic                     wr_en,
   output logic [ADDR_BITS-1:0]     wr_addr,
   output logic [3*COLOR_DEPTH-1:0] wr_data
);

   localparam int PW    = pix_width(COLOR_DEPTH);
   localparam int X_END = WIN_X_START + WIN_WIDTH;
   localparam int Y_END = WIN_Y_START + WIN_HEIGHT;
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(WIN_WIDTH * WIN_HEIGHT - 1);

   cap_state_e          state_q, state_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [PW-1:0]       wr_data_q, wr_data_d;
   logic                err_short_q, err_short_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;

   logic                vs_rise;
   logic                de_fall;
   logic [X_BITS-1:0]   x;
   logic [Y_BITS-1:0]   y;
   logic                in_win;
   logic                last_pix;

   // hs_in is only carried for external monitoring; nothing here depends on it.
   logic unused_hs;
   assign unused_hs = hs_in;

   video_xy_tracker #(
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_xy (
      .pix_clk (pix_clk),
      .rstn    (rstn),
      .vs_in   (vs_in),
      .de_in   (de_in),
      .vs_rise (vs_rise),
      .de_fall (de_fall),
      .x       (x),
      .y       (y)
   );

   // Window membership of the pixel currently on the bus.
   always_comb begin
      in_win = de_in
               && (int'(x) >= WIN_X_START) && (int'(x) < X_END)
               && (int'(y) >= WIN_Y_START) && (int'(y) < Y_END);
      last_pix = in_win && (idx_q == LAST_IDX);
   end

   // Next state, pixel index and registered write/status outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      err_short_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (cap_start) state_d = ST_ARM;
         end
         ST_ARM: begin
            idx_d = '0;
            if (vs_rise) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // The final pixel wins over a coincident frame start.
            if (last_pix) begin
               wr_en_d   = 1'b1;
               wr_addr_d = idx_q;
               wr_data_d = pixel_in;
               idx_d     = '0;
               state_d   = ST_DONE;
            end else if (vs_rise) begin
               err_short_d = 1'b1;
               idx_d       = '0;
            end else if (in_win) begin
               wr_en_d   = 1'b1;
               wr_addr_d = idx_q;
               wr_data_d = pixel_in;
               idx_d     = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = cap_continuous ? ST_ARM : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         err_short_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         err_short_q <= err_short_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign cap_busy  = (state_q != ST_IDLE);
   assign cap_done  = (state_q == ST_DONE);
   assign err_short = err_short_q;
   assign frame_cnt = frame_cnt_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule

// File: doc/video_window_capture.md
Name: video_window_capture

Overview:
- Write-side counterpart of the ROM-driven display path: takes an incoming raster stream (vs/hs/de + 24-bit RGB), tracks active x/y itself, and writes one rectangular window into a dual-port frame-buffer RAM.
- A later display stage reads that buffer the same way the picture ROM is read today.
- Runs in the pix_clk domain, with single-shot or continuous frame capture controlled by a start/busy/done handshake.

Parameters:
- COLOR_DEPTH, 8, bits per colour channel; pixel width is 3*COLOR_DEPTH.
- X_BITS, 12, width of the internal active-x counter.
- Y_BITS, 12, width of the internal active-y counter.
- WIN_X_START, 640, first active column captured.
- WIN_Y_START, 412, first active row captured.
- WIN_WIDTH, 256, window width in pixels.
- WIN_HEIGHT, 256, window height in lines.
- ADDR_BITS, 16, RAM address width; must satisfy 2^ADDR_BITS >= WIN_WIDTH*WIN_HEIGHT.

Ports:
- pix_clk  in  1  pixel clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- vs_in  in  1  vertical sync, active high; a rising edge marks frame start.
- hs_in  in  1  horizontal sync; passed through for monitoring only.
- de_in  in  1  data enable; high during active pixels.
- pixel_in  in  3*COLOR_DEPTH  RGB pixel, valid when de_in is high.
- cap_start  in  1  one-cycle request to arm a capture.
- cap_continuous  in  1  when high, re-arms automatically after each done.
- cap_busy  out  1  high in ARM, CAPTURE and DONE.
- cap_done  out  1  one-cycle pulse when the last window pixel has been written.
- err_short  out  1  one-cycle pulse when a frame ended before the window was complete.
- frame_cnt  out  8  count of completed captures; wraps 255 -> 0.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_BITS  RAM write address.
- wr_data  out  3*COLOR_DEPTH  RAM write data.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
  - Reset mid-capture abandons the frame.
  - No cap_done or err_short is issued.
- Edge detection uses registered copies of vs_in and de_in.
  - vs_rise = vs_in & ~vs_d.
  - de_fall = ~de_in & de_d.
- Active x counter:
  - Cleared on de_fall and on vs_rise.
  - Increments each cycle de_in is high.
  - Saturates at 2^X_BITS-1.
- Active y counter:
  - Cleared on vs_rise.
  - Increments on de_fall.
  - Saturates at 2^Y_BITS-1.
- in_win is asserted when all of the following hold:
  - de_in is high;
  - WIN_X_START <= x < WIN_X_START+WIN_WIDTH;
  - WIN_Y_START <= y < WIN_Y_START+WIN_HEIGHT.
- FSM states and transitions:
  - IDLE: cap_start -> ARM.
  - ARM: vs_rise -> CAPTURE; pixel index cleared to 0.
  - CAPTURE, pixel write: each in_win cycle writes one pixel and increments the pixel index.
  - CAPTURE, last pixel: when the pixel index is WIN_WIDTH*WIN_HEIGHT-1 and in_win is high -> DONE.
  - CAPTURE, early vs_rise (window incomplete):
    - err_short pulses;
    - pixel index resets to 0;
    - capture restarts on the new frame;
    - state stays CAPTURE.
  - DONE (one cycle):
    - cap_done = 1;
    - frame_cnt increments;
    - next state is ARM if cap_continuous is high, else IDLE.
- cap_start outside IDLE is ignored.
- Write timing: one-cycle registered latency.
  - wr_en, wr_addr and wr_data in cycle n+1 reflect in_win, the pixel index and pixel_in from cycle n.
  - wr_addr is the linear index: (y-WIN_Y_START)*WIN_WIDTH + (x-WIN_X_START).
  - The pixel index is kept as a counter; no multiplier.
- cap_done asserts in the same cycle as the final wr_en, i.e. one cycle after the last in_win.
- A vs_rise in the same cycle as the last in_win: the write and DONE win; no err_short.
- A frame whose active area is smaller than the window (y saturates or never reaches the window) is reported by err_short at the next vs_rise.

Decomposition:
- Shared package video_pkg holds:
  - pixel width constant (3*COLOR_DEPTH);
  - FSM state enum {IDLE, ARM, CAPTURE, DONE};
  - default window constants shared with the display side.
- One natural sub-module, video_xy_tracker, covers edge detection and the saturating active x/y counters.
  - The display path can reuse it later.

Test Plan:
- Small parameters for the bench: WIN 4x2 at (2,1), 8 active pixels/line, 4 lines/frame, ADDR_BITS 3.
- Single capture:
  - Stimulus: cap_start, then one frame with pixel_in = 16*y + x.
  - Writes, in order: wr_addr 0..7 with wr_data 0x12,0x13,0x14,0x15,0x22,0x23,0x24,0x25.
  - cap_done coincides with the addr 7 write; frame_cnt = 1; then IDLE with cap_busy = 0.
- Arming: cap_start issued mid-frame -> no writes until the next vs_rise; then the full 8-pixel window is written.
- Short frame: vs_rise arrives after line 1 (only 4 pixels written) -> err_short pulses once; next frame restarts at wr_addr 0 and completes with cap_done.
- Continuous mode: cap_continuous = 1 over 3 frames -> 3 cap_done pulses, frame_cnt = 3, cap_busy stays high.
  - Wrap: frame_cnt preloaded at 255 via 255 captures -> reads 0 after the next capture.
- Reset mid-CAPTURE after 3 writes:
  - Outputs go to 0 immediately; state IDLE.
  - A subsequent cap_start produces a clean capture beginning at wr_addr 0.
